// File: rtl/q_8_8_drv.sv
// q_8_8_drv: initiator for the q_8_8 start/rdy operand interface.
// Issues one Q8.8 operand pair, waits the fixed latency, returns C.
module q_8_8_drv #(
  parameter int RESULT_LAT  = 2,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             start,
  output logic [15:0]      dut_a,
  output logic [15:0]      dut_b,
  input  logic [15:0]      dut_c,
  input  logic             dut_rdy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_c,
  output logic [15:0]      out_a,
  output logic             err,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAP,
    S_OUT
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [LW-1:0] lcnt;

  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      start     <= 1'b0;
      dut_a     <= '0;
      dut_b     <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_a     <= '0;
      err       <= 1'b0;
      txn_cnt   <= '0;
      err_cnt   <= '0;
      tcnt      <= '0;
      lcnt      <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            dut_a <= in_a;
            dut_b <= in_b;
            start <= 1'b1;
            tcnt  <= '0;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (dut_rdy) begin
            start <= 1'b0;
            lcnt  <= LW'(RESULT_LAT - 1);
            // a one-cycle latency has no wait phase at all
            if (RESULT_LAT == 1) state <= S_CAP;
            else                 state <= S_WAIT;
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            start <= 1'b0;
            err   <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (lcnt == LW'(1)) state <= S_CAP;
          else                lcnt  <= lcnt - 1'b1;
        end
        S_CAP: begin
          out_c     <= dut_c;
          out_a     <= dut_a;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            txn_cnt   <= txn_cnt + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_8_8_drv.sv
// tb_q_8_8_drv: random transactions against a q_8_8 unit stand-in
// and a transaction-level expectation of the driver.
module tb_q_8_8_drv;

  localparam int LAT = 2;
  localparam int TO  = 15;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        start;
  logic [15:0] dut_a, dut_b, dut_c;
  logic        dut_rdy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_c, out_a;
  logic        err;
  logic [7:0]  txn_cnt, err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  q_8_8_drv #(.RESULT_LAT(LAT), .TIMEOUT_CYC(TO), .CNT_W(8)) u_dut (
    .clk(clk), .rst_b(rst_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .start(start), .dut_a(dut_a), .dut_b(dut_b),
    .dut_c(dut_c), .dut_rdy(dut_rdy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_a(out_a),
    .err(err), .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // stand-in unit: A<0 -> A>>1, A>0 -> B<<1, A==0 -> C unchanged
  function automatic logic [15:0] unit_fn(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] c);
    if (a == 16'h0)  return c;
    else if (a[15])  return a >> 1;
    else             return b << 1;
  endfunction

  // unit model: C is junk until RESULT_LAT cycles after acceptance
  logic [15:0] u_c  = '0;
  logic [15:0] pend = '0;
  logic [15:0] junk = '0;
  int busy     = 0;
  int req_cyc  = 0;
  int rdy_wait = 0;

  assign dut_rdy = start && (busy == 0) && (req_cyc >= rdy_wait);
  assign dut_c   = (busy != 0) ? junk : u_c;

  always @(posedge clk) begin
    junk <= 16'($urandom);
    if (!start) req_cyc <= 0;
    else        req_cyc <= req_cyc + 1;
    if (start && dut_rdy) begin
      if (LAT == 1) u_c <= unit_fn(dut_a, dut_b, u_c);
      else begin
        busy <= LAT - 1;
        pend <= unit_fn(dut_a, dut_b, u_c);
      end
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) u_c <= pend;
    end
  end

  logic [15:0] ref_c   = '0;
  logic [7:0]  exp_txn = '0;
  logic [7:0]  exp_err = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input logic [15:0] a, input logic [15:0] b,
                        input int d, input int bp);
    int n;
    int k;
    logic [15:0] exp_c;
    logic [15:0] held;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_idle", in_ready, 1);
    rdy_wait = d;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    n = 0;
    while (start && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (d < TO) begin
      chk("start_len", n, d + 1);
      exp_c = unit_fn(a, b, ref_c);
      ref_c = exp_c;
      k = 1;
      while (!out_valid && k < 20) begin
        chk("in_ready_busy", in_ready, 0);
        @(negedge clk);
        k++;
      end
      chk("out_lat", k, LAT + 1);
      chk("out_c", out_c, exp_c);
      chk("out_a", out_a, a);
      held = out_c;
      repeat (bp) begin
        @(negedge clk);
        chk("bp_valid", out_valid, 1);
        chk("bp_c", out_c, held);
        chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_txn = exp_txn + 8'd1;
      chk("hs_valid", out_valid, 0);
      chk("txn_cnt", txn_cnt, exp_txn);
      chk("hs_in_ready", in_ready, 1);
    end else begin
      chk("to_start_len", n, TO);
      chk("to_err", err, 1);
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      chk("to_err_cnt", err_cnt, exp_err);
      chk("to_in_ready", in_ready, 1);
      chk("to_no_valid", out_valid, 0);
      @(negedge clk);
      chk("to_err_pulse", err, 0);
      chk("to_txn_cnt", txn_cnt, exp_txn);
    end
  endtask

  initial begin
    logic [15:0] ra;
    int k;
    rst_b = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_txn", txn_cnt, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_dut_a", dut_a, 0);
    chk("rst_out_c", out_c, 0);
    rst_b = 1'b1;
    @(negedge clk);

    do_txn(16'hFF00, 16'h0100, 0, 0);
    do_txn(16'h0100, 16'h0180, 2, 0);
    do_txn(16'h0000, 16'h1234, 0, 0);
    chk("zero_keeps_c", out_c, 16'h0300);
    do_txn(16'h0100, 16'h0200, 1, 10);
    do_txn(16'h4000, 16'h0001, 100, 0);
    do_txn(16'h8000, 16'h0001, TO - 1, 1);
    do_txn(16'h1111, 16'h2222, TO, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 5) == 0) ra = 16'h0;
      do_txn(ra, 16'($urandom), $urandom_range(0, TO + 1),
             $urandom_range(0, 3));
    end

    // reset while the request is in flight
    rdy_wait = 0;
    in_valid = 1'b1;
    in_a = 16'h0300;
    in_b = 16'h0011;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (start && k < 40) begin
      @(negedge clk);
      k++;
    end
    ref_c = unit_fn(16'h0300, 16'h0011, ref_c);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_start", start, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_txn", txn_cnt, 0);
    chk("mid_rst_errcnt", err_cnt, 0);
    exp_txn = '0;
    exp_err = '0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    do_txn(16'hF000, 16'h0100, 3, 2);
    do_txn(16'h0040, 16'h0123, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
